// File: rtl/cntdn_mmss_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// State encodings, BCD digit limits, alarm-length default and a BCD helper.
package cntdn_mmss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BCD_UNITS_MAX  = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX   = 4'd5;
    localparam int         ALARM_SECS_DEF = 10;

    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
        return ({3'b000, tens} * 7'd10) + {3'b000, units};
    endfunction

endpackage

// File: rtl/cntdn_mmss_if.sv
// Button/tick inputs and digit/status outputs of the countdown timer.
// master drives the buttons and 1 Hz tick, slave is the timer itself.
interface cntdn_mmss_if;

    logic       en1hz;
    logic       clr;
    logic       start_stop;
    logic       min_up;
    logic       sec_up;
    logic [3:0] min_upper;
    logic [3:0] min_lower;
    logic [3:0] sec_upper;
    logic [3:0] sec_lower;
    logic       running;
    logic       alarm;

    modport master (
        output en1hz, clr, start_stop, min_up, sec_up,
        input  min_upper, min_lower, sec_upper, sec_lower, running, alarm
    );

    modport slave (
        input  en1hz, clr, start_stop, min_up, sec_up,
        output min_upper, min_lower, sec_upper, sec_lower, running, alarm
    );

endinterface

// File: rtl/cntdn_mmss_bcd_mod60.sv
// Two-digit BCD register counting 0..MAX_VAL with wrap in both directions.
// Priority: clr, load, then inc/dec; borrow flags a decrement taken at 00.
module bcd_mod60
    import cntdn_mmss_pkg::*;
#(
    parameter int MAX_VAL = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_upper,
    input  logic [3:0] load_lower,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] upper,
    output logic [3:0] lower,
    output logic       borrow
);

    localparam logic [3:0] MAX_UPPER = ((MAX_VAL / 10) > 5) ? BCD_TENS_MAX : 4'(MAX_VAL / 10);
    localparam logic [3:0] MAX_LOWER = 4'(MAX_VAL % 10);

    logic [3:0] upper_r;
    logic [3:0] lower_r;
    logic [3:0] upper_nxt_s;
    logic [3:0] lower_nxt_s;
    logic       at_max_s;
    logic       at_zero_s;

    assign at_max_s  = (bcd_to_bin(upper_r, lower_r) == 7'(MAX_VAL));
    assign at_zero_s = (upper_r == 4'd0) && (lower_r == 4'd0);
    assign borrow    = dec && !inc && at_zero_s;

    // Next-value computation for a single BCD increment or decrement
    always_comb begin
        upper_nxt_s = upper_r;
        lower_nxt_s = lower_r;
        if (inc && !dec) begin
            if (at_max_s) begin
                upper_nxt_s = 4'd0;
                lower_nxt_s = 4'd0;
            end else if (lower_r == BCD_UNITS_MAX) begin
                upper_nxt_s = upper_r + 4'd1;
                lower_nxt_s = 4'd0;
            end else begin
                lower_nxt_s = lower_r + 4'd1;
            end
        end else if (dec && !inc) begin
            if (at_zero_s) begin
                upper_nxt_s = MAX_UPPER;
                lower_nxt_s = MAX_LOWER;
            end else if (lower_r == 4'd0) begin
                upper_nxt_s = upper_r - 4'd1;
                lower_nxt_s = BCD_UNITS_MAX;
            end else begin
                lower_nxt_s = lower_r - 4'd1;
            end
        end else begin
            upper_nxt_s = upper_r;
            lower_nxt_s = lower_r;
        end
    end

    // Digit register with clear and load override
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upper_r <= 4'd0;
            lower_r <= 4'd0;
        end else if (clr) begin
            upper_r <= 4'd0;
            lower_r <= 4'd0;
        end else if (load) begin
            upper_r <= load_upper;
            lower_r <= load_lower;
        end else begin
            upper_r <= upper_nxt_s;
            lower_r <= lower_nxt_s;
        end
    end

    assign upper = upper_r;
    assign lower = lower_r;

endmodule

// File: rtl/cntdn_mmss.sv
// MM:SS countdown timer: preset with set buttons, run/pause, alarm at 00:00.
// Optional macro CNTDN_AUTORELOAD_EN reloads the last started preset after the alarm.
module cntdn_mmss
    import cntdn_mmss_pkg::*;
#(
    parameter int ALARM_SECS = ALARM_SECS_DEF,
    parameter int MAX_MIN    = 59
) (
    input logic         CLK,
    input logic         RST,
    cntdn_mmss_if.slave bus
);

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);

    state_t     state_r;
    logic [7:0] alarm_cnt_r;
    logic       running_r;
    logic       alarm_r;

    logic [3:0] min_upper_s, min_lower_s, sec_upper_s, sec_lower_s;
    logic [3:0] load_min_upper_s, load_min_lower_s, load_sec_upper_s, load_sec_lower_s;
    logic       sec_borrow_s, min_borrow_s;
    logic       setting_s, time_zero_s, start_ok_s, tick_s, hits_zero_s;
    logic       ack_s, timeout_s, leave_alarm_s, load_s;
    logic       sec_inc_s, min_inc_s;

    assign setting_s   = (state_r == ST_IDLE) || (state_r == ST_PAUSE);
    assign time_zero_s = ({min_upper_s, min_lower_s, sec_upper_s, sec_lower_s} == 16'h0000);
    assign start_ok_s  = !bus.clr && setting_s && bus.start_stop && !time_zero_s;
    assign sec_inc_s   = !bus.clr && setting_s && bus.sec_up;
    assign min_inc_s   = !bus.clr && setting_s && bus.min_up;
    // A pause request wins over a coincident tick, so the display freezes as shown
    assign tick_s      = !bus.clr && (state_r == ST_RUN) && bus.en1hz && !bus.start_stop;
    assign hits_zero_s = tick_s && ({min_upper_s, min_lower_s, sec_upper_s, sec_lower_s} == 16'h0001);
    assign ack_s       = (state_r == ST_ALARM) && (bus.start_stop || bus.min_up || bus.sec_up);
    assign timeout_s   = (state_r == ST_ALARM) && bus.en1hz && (alarm_cnt_r == ALARM_LAST);
    assign leave_alarm_s = !bus.clr && (ack_s || timeout_s);

`ifdef CNTDN_AUTORELOAD_EN
    logic [15:0] preset_r;

    // Preset captured only on IDLE->RUN so that resuming from PAUSE keeps the original value
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            preset_r <= 16'h0000;
        end else if (bus.clr) begin
            preset_r <= 16'h0000;
        end else if ((state_r == ST_IDLE) && start_ok_s) begin
            preset_r <= {min_upper_s, min_lower_s, sec_upper_s, sec_lower_s};
        end
    end

    assign load_s = leave_alarm_s;
    assign {load_min_upper_s, load_min_lower_s, load_sec_upper_s, load_sec_lower_s} = preset_r;
`else
    assign load_s = 1'b0;
    assign {load_min_upper_s, load_min_lower_s, load_sec_upper_s, load_sec_lower_s} = 16'h0000;
`endif

    bcd_mod60 #(.MAX_VAL(59)) u_sec (
        .clk        (CLK),
        .rst        (RST),
        .clr        (bus.clr),
        .load       (load_s),
        .load_upper (load_sec_upper_s),
        .load_lower (load_sec_lower_s),
        .inc        (sec_inc_s),
        .dec        (tick_s),
        .upper      (sec_upper_s),
        .lower      (sec_lower_s),
        .borrow     (sec_borrow_s)
    );

    bcd_mod60 #(.MAX_VAL(MAX_MIN)) u_min (
        .clk        (CLK),
        .rst        (RST),
        .clr        (bus.clr),
        .load       (load_s),
        .load_upper (load_min_upper_s),
        .load_lower (load_min_lower_s),
        .inc        (min_inc_s),
        .dec        (sec_borrow_s),
        .upper      (min_upper_s),
        .lower      (min_lower_s),
        .borrow     (min_borrow_s)
    );

    // Control FSM with alarm duration counter and registered status flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            alarm_cnt_r <= 8'd0;
            running_r   <= 1'b0;
            alarm_r     <= 1'b0;
        end else if (bus.clr) begin
            state_r     <= ST_IDLE;
            alarm_cnt_r <= 8'd0;
            running_r   <= 1'b0;
            alarm_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_PAUSE: begin
                    if (start_ok_s) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.start_stop) begin
                        state_r   <= ST_PAUSE;
                        running_r <= 1'b0;
                    end else if (hits_zero_s || min_borrow_s) begin
                        // minute borrow is unreachable; treat it as expiry rather than wrap
                        state_r     <= ST_ALARM;
                        running_r   <= 1'b0;
                        alarm_r     <= 1'b1;
                        alarm_cnt_r <= 8'd0;
                    end
                end
                ST_ALARM: begin
                    if (leave_alarm_s) begin
                        state_r     <= ST_IDLE;
                        alarm_r     <= 1'b0;
                        alarm_cnt_r <= 8'd0;
                    end else if (bus.en1hz) begin
                        alarm_cnt_r <= alarm_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    alarm_cnt_r <= 8'd0;
                    running_r   <= 1'b0;
                    alarm_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.min_upper = min_upper_s;
    assign bus.min_lower = min_lower_s;
    assign bus.sec_upper = sec_upper_s;
    assign bus.sec_lower = sec_lower_s;
    assign bus.running   = running_r;
    assign bus.alarm     = alarm_r;

endmodule

// File: tb/tb_cntdn_mmss.sv
// Directed self-checking bench for the MM:SS countdown timer.
// Time is compared as a 16-bit BCD word MMSS (e.g. 16'h0259 = 02:59).
module tb_cntdn_mmss;

    logic CLK;
    logic RST;
    int   checks   = 0;
    int   failures = 0;

    cntdn_mmss_if bus ();

    cntdn_mmss #(.ALARM_SECS(10), .MAX_MIN(59)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [15:0] tm;
    assign tm = {bus.min_upper, bus.min_lower, bus.sec_upper, bus.sec_lower};

`ifdef CNTDN_AUTORELOAD_EN
    localparam logic [15:0] AFTER_ALARM_2 = 16'h0002;
    localparam logic [15:0] AFTER_ACK_1   = 16'h0001;
    localparam logic [15:0] AFTER_ACK_INC = 16'h0002;
    localparam logic        RESTART_RUN   = 1'b1;
`else
    localparam logic [15:0] AFTER_ALARM_2 = 16'h0000;
    localparam logic [15:0] AFTER_ACK_1   = 16'h0000;
    localparam logic [15:0] AFTER_ACK_INC = 16'h0001;
    localparam logic        RESTART_RUN   = 1'b0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock with the given pulses; returns 1 time unit after the edge
    task automatic cyc(input logic c, input logic ss, input logic mu, input logic su, input logic e);
        bus.clr = c; bus.start_stop = ss; bus.min_up = mu; bus.sec_up = su; bus.en1hz = e;
        @(posedge CLK);
        #1;
        bus.clr = 1'b0; bus.start_stop = 1'b0; bus.min_up = 1'b0; bus.sec_up = 1'b0; bus.en1hz = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.clr = 1'b0; bus.start_stop = 1'b0; bus.min_up = 1'b0; bus.sec_up = 1'b0; bus.en1hz = 1'b0;
        @(posedge CLK);
        #1;
        checks++; if (tm !== 16'h0000) begin failures++; $display("FAIL reset_time got=%h exp=%h", tm, 16'h0000); end
        checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", bus.running); end
        checks++; if (bus.alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b exp=0", bus.alarm); end
        RST = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (tm !== 16'h0130) begin failures++; $display("FAIL async_preset got=%h exp=%h", tm, 16'h0130); end
        checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL async_running got=%b exp=1", bus.running); end
        #3;
        RST = 1'b1;
        #1;
        checks++; if (tm !== 16'h0000) begin failures++; $display("FAIL async_rst_time got=%h exp=%h", tm, 16'h0000); end
        checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL async_rst_running got=%b exp=0", bus.running); end
        checks++; if (bus.alarm !== 1'b0) begin failures++; $display("FAIL async_rst_alarm got=%b exp=0", bus.alarm); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_preset_run();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (tm !== 16'h0305) begin failures++; $display("FAIL preset_value got=%h exp=%h", tm, 16'h0305); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (tm !== 16'h0304) begin failures++; $display("FAIL run_tick1 got=%h exp=%h", tm, 16'h0304); end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL run_running got=%b exp=1", bus.running); end
        end
        checks++; if (tm !== 16'h0259) begin failures++; $display("FAIL run_tick6_borrow got=%h exp=%h", tm, 16'h0259); end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (tm !== 16'h0259) begin failures++; $display("FAIL run_set_ignored got=%h exp=%h", tm, 16'h0259); end
    endtask

    task automatic test_alarm();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (tm !== 16'h0001) begin failures++; $display("FAIL alarm_tick1 got=%h exp=%h", tm, 16'h0001); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if ({tm, bus.alarm, bus.running} !== {16'h0000, 1'b1, 1'b0}) begin
            failures++; $display("FAIL alarm_reach_zero got=%h/%b/%b exp=0000/1/0", tm, bus.alarm, bus.running);
        end
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.alarm !== 1'b1) begin failures++; $display("FAIL alarm_hold9 got=%b exp=1", bus.alarm); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.alarm !== 1'b0) begin failures++; $display("FAIL alarm_timeout got=%b exp=0", bus.alarm); end
        checks++; if (tm !== AFTER_ALARM_2) begin failures++; $display("FAIL alarm_after_time got=%h exp=%h", tm, AFTER_ALARM_2); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.running !== RESTART_RUN) begin failures++; $display("FAIL alarm_restart got=%b exp=%b", bus.running, RESTART_RUN); end
    endtask

    task automatic test_pause();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if ({tm, bus.running} !== {16'h0010, 1'b0}) begin
            failures++; $display("FAIL pause_coincident got=%h/%b exp=0010/0", tm, bus.running);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (tm !== 16'h0011) begin failures++; $display("FAIL pause_set got=%h exp=%h", tm, 16'h0011); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL pause_resume got=%b exp=1", bus.running); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (tm !== 16'h0010) begin failures++; $display("FAIL pause_resume_tick got=%h exp=%h", tm, 16'h0010); end
    endtask

    task automatic test_idle_zero();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if ({tm, bus.running} !== {16'h0000, 1'b0}) begin
            failures++; $display("FAIL zero_start_ignored got=%h/%b exp=0000/0", tm, bus.running);
        end
        for (int i = 0; i < 59; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (tm !== 16'h0059) begin failures++; $display("FAIL sec_59 got=%h exp=%h", tm, 16'h0059); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (tm !== 16'h0000) begin failures++; $display("FAIL sec_wrap got=%h exp=%h", tm, 16'h0000); end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (tm !== 16'h0101) begin failures++; $display("FAIL both_set got=%h exp=%h", tm, 16'h0101); end
        for (int i = 0; i < 58; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (tm !== 16'h5901) begin failures++; $display("FAIL min_59 got=%h exp=%h", tm, 16'h5901); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (tm !== 16'h0001) begin failures++; $display("FAIL min_wrap got=%h exp=%h", tm, 16'h0001); end
    endtask

    task automatic test_clr_and_ack();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if ({tm, bus.running} !== {16'h1000, 1'b1}) begin
            failures++; $display("FAIL clr_setup got=%h/%b exp=1000/1", tm, bus.running);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if ({tm, bus.running, bus.alarm} !== {16'h0000, 1'b0, 1'b0}) begin
            failures++; $display("FAIL clr_with_tick got=%h/%b/%b exp=0000/0/0", tm, bus.running, bus.alarm);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.alarm !== 1'b1) begin failures++; $display("FAIL ack_setup got=%b exp=1", bus.alarm); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if ({tm, bus.alarm} !== {AFTER_ACK_1, 1'b0}) begin
            failures++; $display("FAIL ack_min_up got=%h/%b exp=%h/0", tm, bus.alarm, AFTER_ACK_1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (tm !== AFTER_ACK_INC) begin failures++; $display("FAIL ack_then_idle got=%h exp=%h", tm, AFTER_ACK_INC); end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_preset_run();
        test_alarm();
        test_pause();
        test_idle_zero();
        test_clr_and_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
